// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect and decode handshake.
// Optional FETCH_PERF_EN adds the fetch_cnt_o performance counter output.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_o;
`endif

  modport master (
`ifdef FETCH_PERF_EN
    output fetch_cnt_o,
`endif
    output imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
    input  imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
`ifdef FETCH_PERF_EN
    input  fetch_cnt_o,
`endif
    input  imem_req_o, imem_addr_o, instr_o, pc_o, instr_valid_o,
    output imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, 2-entry FIFO to decode.
// Define FETCH_PERF_EN to add the fetch_cnt_o popped-instruction counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk_i,
  input logic           rst_i,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] reqPc_q, reqPc_d;
  logic [31:0] instr0_q, instr0_d, pc0_q, pc0_d;
  logic [31:0] instr1_q, instr1_d, pc1_q, pc1_d;
  logic [1:0]  count_q, count_d, countAfter;
  logic        headValid, push, pop, issue;

  assign headValid  = (count_q != 2'd0);
  assign pop        = headValid && bus.instr_ready_i;
  assign push       = !bus.redirect_i && (state_q == WAIT) && bus.imem_rvalid_i;
  assign countAfter = count_q + {1'b0, push} - {1'b0, pop};

  // A request may issue only if the FIFO still has room for its response.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    reqPc_d   = reqPc_q;
    issue     = 1'b0;
    if (bus.redirect_i) begin
      fetchPc_d = bus.redirect_pc_i & 32'hFFFF_FFFC;
      state_d   = ((state_q != IDLE) && !bus.imem_rvalid_i) ? DROP : IDLE;
    end else begin
      case (state_q)
        IDLE: issue = !rst_i && (countAfter < 2'd2);
        WAIT: begin
          if (bus.imem_rvalid_i) begin
            state_d = IDLE;
            issue   = countAfter < 2'd2;
          end
        end
        DROP: if (bus.imem_rvalid_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (issue) begin
        state_d   = WAIT;
        reqPc_d   = fetchPc_q;
        fetchPc_d = fetchPc_q + 32'd4;
      end
    end
  end

  // Head entry keeps its old contents when the FIFO drains so instr_o/pc_o hold.
  always_comb begin
    instr0_d = instr0_q;
    pc0_d    = pc0_q;
    instr1_d = instr1_q;
    pc1_d    = pc1_q;
    count_d  = count_q;
    if (bus.redirect_i) begin
      count_d = 2'd0;
    end else begin
      case ({pop, push})
        2'b01: begin
          if (count_q == 2'd0) begin
            instr0_d = bus.imem_rdata_i;
            pc0_d    = reqPc_q;
          end else begin
            instr1_d = bus.imem_rdata_i;
            pc1_d    = reqPc_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd2) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
            instr1_d = bus.imem_rdata_i;
            pc1_d    = reqPc_q;
          end else begin
            instr0_d = bus.imem_rdata_i;
            pc0_d    = reqPc_q;
          end
        end
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
      reqPc_q   <= RESET_PC;
      instr0_q  <= 32'd0;
      pc0_q     <= 32'd0;
      instr1_q  <= 32'd0;
      pc1_q     <= 32'd0;
      count_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      reqPc_q   <= reqPc_d;
      instr0_q  <= instr0_d;
      pc0_q     <= pc0_d;
      instr1_q  <= instr1_d;
      pc1_q     <= pc1_d;
      count_q   <= count_d;
    end
  end

  assign bus.imem_req_o    = issue;
  assign bus.imem_addr_o   = fetchPc_q;
  assign bus.instr_valid_o = headValid;
  assign bus.instr_o       = instr0_q;
  assign bus.pc_o          = pc0_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetchCnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fetchCnt_q <= 32'd0;
    else if (pop) fetchCnt_q <= fetchCnt_q + 32'd1;
  end

  assign bus.fetch_cnt_o = fetchCnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle (stallable) memory model.
// Covers the FETCH_PERF_EN counter when that macro is defined.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;
  int   hsCount;

  logic        memPending;
  logic [31:0] memAddr;
  logic [31:0] obsReq, obsAddr, obsValid, obsInstr, obsPc;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One cycle: deliver any pending memory response, drive inputs, sample outputs mid-cycle.
  task automatic applyStimulus(input logic rstV, input logic redir, input logic [31:0] rpc,
                               input logic rdy, input logic stall);
    @(posedge clk);
    #1;
    if (memPending && !stall) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = memAddr;
      memPending        = 1'b0;
    end else begin
      bus.imem_rvalid_i = 1'b0;
    end
    rst               = rstV;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.instr_ready_i = rdy;
    if (rstV) hsCount = 0;
    @(negedge clk);
    obsReq   = 32'(bus.imem_req_o);
    obsAddr  = bus.imem_addr_o;
    obsValid = 32'(bus.instr_valid_o);
    obsInstr = bus.instr_o;
    obsPc    = bus.pc_o;
    if (bus.imem_req_o) begin
      memPending = 1'b1;
      memAddr    = bus.imem_addr_o;
    end
    if (bus.instr_valid_o && bus.instr_ready_i) hsCount++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    nChecks = 0;
    nFails = 0;
    hsCount = 0;
    memPending = 1'b0;
    memAddr = 32'd0;
    rst = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = 32'd0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'd0;
    bus.instr_ready_i = 1'b1;

    // Reset state and streaming with decode always ready
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("rst_req", obsReq, 32'd0);
    checkOutput("rst_addr", obsAddr, 32'd0);
    checkOutput("rst_valid", obsValid, 32'd0);
    checkOutput("rst_instr", obsInstr, 32'd0);
    checkOutput("rst_pc", obsPc, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("s1_req", obsReq, 32'd1);
    checkOutput("s1_addr", obsAddr, 32'h0);
    checkOutput("s1_valid", obsValid, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("s2_req", obsReq, 32'd1);
    checkOutput("s2_addr", obsAddr, 32'h4);
    checkOutput("s2_valid", obsValid, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("s3_valid", obsValid, 32'd1);
    checkOutput("s3_pc", obsPc, 32'h0);
    checkOutput("s3_instr", obsInstr, 32'h0);
    checkOutput("s3_addr", obsAddr, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("s4_pc", obsPc, 32'h4);
    checkOutput("s4_instr", obsInstr, 32'h4);
    checkOutput("s4_addr", obsAddr, 32'hC);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("s5_pc", obsPc, 32'h8);

    // Mid-stream reset; held response arrives after release and must be ignored
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("mrst_valid", obsValid, 32'd0);
    checkOutput("mrst_req", obsReq, 32'd0);
    checkOutput("mrst_addr", obsAddr, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("f1_req", obsReq, 32'd1);
    checkOutput("f1_addr", obsAddr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("f2_valid", obsValid, 32'd0);
    checkOutput("f2_addr", obsAddr, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("f3_valid", obsValid, 32'd1);
    checkOutput("f3_pc", obsPc, 32'h0);
    checkOutput("f3_req", obsReq, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("f4_req", obsReq, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("f5_req", obsReq, 32'd0);
    checkOutput("f5_pc", obsPc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("f6_req", obsReq, 32'd1);
    checkOutput("f6_addr", obsAddr, 32'h8);
    checkOutput("f6_pc", obsPc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("f7_pc", obsPc, 32'h4);
    checkOutput("f7_instr", obsInstr, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("f8_pc", obsPc, 32'h8);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("f9_pc", obsPc, 32'hC);

    // Redirect while a response is outstanding: old word dropped
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("d1_addr", obsAddr, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    checkOutput("d2_req", obsReq, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("d3_req", obsReq, 32'd0);
    checkOutput("d3_valid", obsValid, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("d4_req", obsReq, 32'd1);
    checkOutput("d4_addr", obsAddr, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("d5_valid", obsValid, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("d6_valid", obsValid, 32'd1);
    checkOutput("d6_pc", obsPc, 32'h100);
    checkOutput("d6_instr", obsInstr, 32'h100);

    // Redirect with same-cycle response, unaligned target
    applyStimulus(1'b0, 1'b1, 32'h203, 1'b1, 1'b0);
    checkOutput("r7_req", obsReq, 32'd0);
    checkOutput("r7_pc", obsPc, 32'h104);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("r8_valid", obsValid, 32'd0);
    checkOutput("r8_req", obsReq, 32'd1);
    checkOutput("r8_addr", obsAddr, 32'h200);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("r9_addr", obsAddr, 32'h204);

    // PC wrap from the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    checkOutput("w10_pc", obsPc, 32'h200);
    checkOutput("w10_req", obsReq, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("w11_addr", obsAddr, 32'hFFFF_FFFC);
    checkOutput("w11_valid", obsValid, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("w12_req", obsReq, 32'd1);
    checkOutput("w12_addr", obsAddr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("w13_pc", obsPc, 32'hFFFF_FFFC);
    checkOutput("w13_instr", obsInstr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("w14_pc", obsPc, 32'h0);

`ifdef FETCH_PERF_EN
    // Counter over 10 accepted instructions with one redirect, then reset pulse
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("p_rst_cnt", bus.fetch_cnt_o, 32'd0);
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, (i == 5) ? 1'b1 : 1'b0, 32'h40, 1'b1, 1'b0);
      if (hsCount >= 10) break;
    end
    checkOutput("p_hs", 32'(hsCount), 32'd10);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("p_cnt10", bus.fetch_cnt_o, 32'd10);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("p_cnt0", bus.fetch_cnt_o, 32'd0);
    checkOutput("p_valid0", obsValid, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("p_idle_req", obsReq, 32'd1);
    checkOutput("p_idle_addr", obsAddr, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decode unit. It holds the program counter and issues word requests to instruction memory with at most one request outstanding. Returned words are buffered with their PC in a 2-entry FIFO and presented to decode over a valid/ready handshake. A redirect from execute (branch/jump taken) flushes the FIFO and any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset (bits [1:0] must be 0)
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- imem_req_o  output  1  single-cycle request strobe; memory always accepts
- imem_addr_o  output  32  word address of request (byte address, [1:0]=0)
- imem_rvalid_i  input  1  response valid, ≥1 cycle after request, in order
- imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i
- redirect_i  input  1  taken branch/jump; highest priority
- redirect_pc_i  input  32  new PC; bits [1:0] ignored (forced 0)
- instr_o  output  32  instruction to decode (feeds decode instr_i)
- pc_o  output  32  PC of instr_o
- instr_valid_o  output  1  FIFO head valid
- instr_ready_i  input  1  decode accepts head this cycle

## Operation
- State machine: IDLE (nothing outstanding), WAIT (one request outstanding), DROP (outstanding response to be discarded).
- Issue condition: not redirect_i, and (IDLE or (WAIT and imem_rvalid_i)), and fifo_count − pop + push(this cycle) + 0 < 2 after accounting for the new request; i.e. occupancy + outstanding ≤ 1 after this cycle's push/pop. Issue drives imem_req_o=1, imem_addr_o=fetch_pc, fetch_pc += 4 (wraps modulo 2^32), state→WAIT.
- WAIT + imem_rvalid_i: push {imem_rdata_i, req_pc} into FIFO; state→IDLE unless a new request issues same cycle (stays WAIT).
- Pop when instr_valid_o && instr_ready_i. Push and pop in same cycle allowed at any occupancy, including full.
- Redirect (any state): FIFO cleared, fetch_pc ← {redirect_pc_i[31:2],2'b00}, no request issued that cycle. If WAIT and imem_rvalid_i not asserted same cycle → DROP; otherwise → IDLE (a same-cycle response is discarded).
- DROP + imem_rvalid_i: response discarded, →IDLE. Redirect in DROP stays DROP with updated fetch_pc.
- instr_valid_o, instr_o, pc_o come directly from FIFO head registers; instr_o/pc_o hold last value when invalid.

## Timing
- Reset: state IDLE, fetch_pc=RESET_PC, FIFO empty, imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0.
- First request in first cycle after rst_i deasserts.
- Latency: rvalid in cycle N → instr_valid_o high in N+1.
- 1-cycle memory with decode always ready: one instruction per cycle sustained.
- Redirect in cycle N: instr_valid_o=0 in N+1; request to new PC in N+1 (IDLE) or in cycle after dropped response (DROP).
- Decode stall (instr_ready_i=0) with FIFO full: no request issued, no response lost.
- rst_i mid-operation: immediate return to reset values; a response arriving after reset release without a request is ignored (IDLE ignores imem_rvalid_i).

## Configuration
- FETCH_PERF_EN defined: adds output fetch_cnt_o[31:0], counts instructions popped to decode; reset 0, wraps at 2^32, not cleared by redirect.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, 1-cycle memory returning addr-as-data, ready=1 → requests 0x0,0x4,0x8… one per cycle; instr_valid_o from cycle 3 with pc_o=instr_o=0x0,0x4,…
- ready=0 for 5 cycles → FIFO holds 2 entries (0x0,0x4), only 2 requests issued; ready=1 → pops in order, no duplicates or gaps.
- Redirect to 0x100 while WAIT, response for old PC next cycle → old word dropped, next request 0x100, first delivered pc_o=0x100.
- Redirect same cycle as rvalid → response discarded, request 0x100 next cycle, no DROP state.
- redirect_pc_i=0x103 → fetch at 0x100; fetch_pc 0xFFFF_FFFC → next request 0x0000_0000.
- FETCH_PERF_EN build: 10 accepted instructions with one redirect → fetch_cnt_o=10; rst_i pulse mid-stream → 0 and state IDLE.
